// File: rtl/conv_layer_accum_act.sv
// Post-convolution stage: sums NUM_CH channel results plus bias, saturates, applies ReLU, stores into an output RAM.
// Latency: READ_LAT+3 cycles per output pixel, N*(READ_LAT+3) cycles from start to done; readback port has 1-cycle latency.
// Backpressure: none; start is ignored while busy, and readback data holds its last value while a pass owns the RAM.
// Optional feature macro: LEAKY_RELU_EN (negative values become x >>> LEAK_SHIFT instead of 0).
module conv_layer_accum_act #(
   parameter int NUM_CH     = 2,
   parameter int INT_W      = 10,
   parameter int FRAC_W     = 10,
   parameter int OUT_SIZE   = 26,
   parameter int READ_LAT   = 4,
   parameter int ADDR_W     = 13,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic [ADDR_W-1:0]                 conv_rd_addr,
   output logic                              conv_rd_en,
   input  logic [NUM_CH*(INT_W+FRAC_W)-1:0]  conv_rd_data,
   input  logic [INT_W+FRAC_W-1:0]           bias,
   input  logic [ADDR_W-1:0]                 out_rd_addr,
   output logic [INT_W+FRAC_W-1:0]           out_rd_data,
   output logic                              busy,
   output logic                              done
);

   localparam int D      = INT_W + FRAC_W;
   localparam int N      = OUT_SIZE * OUT_SIZE;
   localparam int SUM_W  = D + $clog2(NUM_CH + 1);
   localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int RAM_AW = (N > 1) ? $clog2(N) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(READ_LAT - 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-D+1){1'b0}}, {(D-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-D+1){1'b1}}, {(D-1){1'b0}}};

   // Reject parameter sets the datapath cannot honour
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("NUM_CH must be at least 1");
   end
   if (READ_LAT < 1) begin : g_bad_read_lat
      $error("READ_LAT must be at least 1");
   end
   if ((64'd1 << ADDR_W) < 64'(N)) begin : g_bad_addr_w
      $error("ADDR_W too small for OUT_SIZE*OUT_SIZE outputs");
   end
   if (LEAK_SHIFT < 0 || LEAK_SHIFT >= D) begin : g_bad_leak_shift
      $error("LEAK_SHIFT must lie in [0, D-1]");
   end

   typedef enum logic [2:0] {IDLE, WAIT_RD, ACC, WRITE, NEXT, DONE} state_t;

   state_t                    state;
   logic [CNT_W-1:0]          wait_cnt;
   logic [D-1:0]              bias_reg;
   logic [D-1:0]              act_reg;
   logic signed [SUM_W-1:0]   sum;
   logic signed [D-1:0]       ch_v;
   logic signed [D-1:0]       sat_v;
   logic [D-1:0]              act_v;
   logic [D-1:0]              ram [0:N-1];

   // Widened sum of all channels plus latched bias, then clamp and activation
   always_comb begin
      ch_v = '0;
      sum  = {{(SUM_W-D){bias_reg[D-1]}}, bias_reg};
      for (int k = 0; k < NUM_CH; k++) begin
         ch_v = conv_rd_data[k*D +: D];
         sum  = sum + {{(SUM_W-D){ch_v[D-1]}}, ch_v};
      end
      if (sum > SAT_MAX)
         sat_v = SAT_MAX[D-1:0];
      else if (sum < SAT_MIN)
         sat_v = SAT_MIN[D-1:0];
      else
         sat_v = sum[D-1:0];
`ifdef LEAKY_RELU_EN
      act_v = sat_v[D-1] ? (sat_v >>> LEAK_SHIFT) : sat_v;
`else
      act_v = sat_v[D-1] ? '0 : sat_v;
`endif
   end

   // Control FSM walking every output address once per pass, all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         conv_rd_addr <= '0;
         conv_rd_en   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         wait_cnt     <= '0;
         bias_reg     <= '0;
         act_reg      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  bias_reg     <= bias;
                  conv_rd_addr <= '0;
                  conv_rd_en   <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  wait_cnt     <= '0;
                  state        <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (wait_cnt == LAST_WAIT) begin
                  wait_cnt <= '0;
                  state    <= ACC;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACC: begin
               act_reg <= act_v;
               state   <= WRITE;
            end
            WRITE: begin
               state <= NEXT;
            end
            NEXT: begin
               if (conv_rd_addr < LAST_ADDR) begin
                  conv_rd_addr <= conv_rd_addr + 1'b1;
                  state        <= WAIT_RD;
               end else begin
                  conv_rd_en <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result RAM write port, driven only from the WRITE state
   always_ff @(posedge clk) begin
      if (state == WRITE)
         ram[conv_rd_addr[RAM_AW-1:0]] <= act_reg;
   end

   // Registered readback, frozen while a pass owns the RAM; addresses past the map read as zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         out_rd_data <= '0;
      else if (!busy)
         out_rd_data <= (out_rd_addr > LAST_ADDR) ? '0 : ram[out_rd_addr[RAM_AW-1:0]];
   end

endmodule
